// File: rtl/dma_oam_ctrl.sv
// OAM DMA controller: a CPU write to the trigger register copies DMA_LENGTH
// bytes from {source page, index} into OAM, one READ/WRITE cycle pair per byte.
module dma_oam_ctrl #(
    parameter int          DMA_LENGTH   = 160,
    parameter logic [15:0] OAM_BASE     = 16'hfe00,
    parameter logic [15:0] DMA_REG_ADDR = 16'hff46
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [15:0] iCpuAddr,
    input  logic        iCpuWe,
    input  logic [7:0]  iCpuData,
    input  logic [7:0]  iMemReadData,
    output logic [15:0] oDmaAddr,
    output logic        oDmaWe,
    output logic [7:0]  oDmaData,
    output logic        oDmaActive,
    output logic [7:0]  oDmaReg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [7:0] LAST_INDEX = 8'(DMA_LENGTH - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] index;
    logic [7:0] index_next;
    logic [7:0] src_hi;
    logic [7:0] dma_reg;
    logic       trigger;

    // Pages e0-ff are echo RAM; fold them back onto the c0-df work RAM pages.
    function automatic logic [7:0] map_src(input logic [7:0] h);
        logic [7:0] r;
        if (h >= 8'he0) begin
            r = h & 8'hdf;
        end else begin
            r = h;
        end
        return r;
    endfunction

    assign trigger = iCpuWe && (iCpuAddr == DMA_REG_ADDR);
    assign oDmaReg = dma_reg;

    // State, index and trigger-register storage.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state   <= IDLE;
            index   <= 8'h00;
            src_hi  <= 8'h00;
            dma_reg <= 8'h00;
        end else begin
            state <= state_next;
            index <= index_next;
            if (trigger) begin
                dma_reg <= iCpuData;
                src_hi  <= map_src(iCpuData);
            end else begin
                dma_reg <= dma_reg;
                src_hi  <= src_hi;
            end
        end
    end

    // Next-state logic; a trigger in any state (re)starts the transfer.
    always_comb begin
        state_next = state;
        index_next = index;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_next = START;
                    index_next = 8'h00;
                end else begin
                    state_next = IDLE;
                end
            end
            START: begin
                index_next = 8'h00;
                if (trigger) begin
                    state_next = START;
                end else begin
                    state_next = READ;
                end
            end
            READ: begin
                if (trigger) begin
                    state_next = START;
                    index_next = 8'h00;
                end else begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (trigger) begin
                    state_next = START;
                    index_next = 8'h00;
                end else if (index == LAST_INDEX) begin
                    state_next = IDLE;
                    index_next = 8'h00;
                end else begin
                    state_next = READ;
                    index_next = index + 8'h01;
                end
            end
            default: begin
                state_next = IDLE;
                index_next = 8'h00;
            end
        endcase
    end

    // Bus outputs decode only registered state, so the CPU bus never reaches oDmaWe.
    always_comb begin
        oDmaAddr   = 16'h0000;
        oDmaWe     = 1'b0;
        oDmaData   = 8'h00;
        oDmaActive = 1'b0;
        case (state)
            IDLE: begin
                oDmaActive = 1'b0;
            end
            START: begin
                oDmaActive = 1'b1;
            end
            READ: begin
                oDmaActive = 1'b1;
                oDmaAddr   = {src_hi, index};
            end
            WRITE: begin
                oDmaActive = 1'b1;
                oDmaWe     = 1'b1;
                oDmaAddr   = OAM_BASE + {8'h00, index};
                oDmaData   = iMemReadData;
            end
            default: begin
                oDmaActive = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_oam_ctrl.sv
// Scoreboard bench for dma_oam_ctrl: expected OAM writes are queued by the
// stimulus, and a negedge monitor pops and compares every oDmaWe pulse.
module tb_dma_oam_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_data;
    logic [7:0]  mem_data;
    logic [15:0] dma_addr;
    logic        dma_we;
    logic [7:0]  dma_data;
    logic        dma_active;
    logic [7:0]  dma_reg;

    int n_cmp = 0;
    int n_err = 0;
    logic [23:0] exp_q[$];

    dma_oam_ctrl dut (
        .iClock      (clk),
        .iReset      (rst),
        .iCpuAddr    (cpu_addr),
        .iCpuWe      (cpu_we),
        .iCpuData    (cpu_data),
        .iMemReadData(mem_data),
        .oDmaAddr    (dma_addr),
        .oDmaWe      (dma_we),
        .oDmaData    (dma_data),
        .oDmaActive  (dma_active),
        .oDmaReg     (dma_reg)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5a;
    endfunction

    // Memory model: data for the address presented this cycle appears next cycle.
    always @(posedge clk) mem_data <= mem_fn(dma_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every OAM write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (dma_we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", dma_addr, dma_data);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("write_addr", {16'h0000, dma_addr}, {16'h0000, e[23:8]});
                check("write_data", {24'h000000, dma_data}, {24'h000000, e[7:0]});
            end
        end
    end

    task automatic push_xfer(input logic [7:0] h, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            logic [15:0] src;
            logic [15:0] dst;
            src = {h, 8'(i)};
            dst = 16'hfe00 + 16'(i);
            exp_q.push_back({dst, mem_fn(src)});
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_data = d;
        cpu_we   = 1'b1;
        step(1);
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_data = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int cnt;
        cnt = 0;
        while (dma_active && cnt < 2000) begin
            cnt++;
            step(1);
        end
        if (cnt >= 2000) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got still active expected idle", name);
        end
    endtask

    initial begin
        int cnt;
        rst      = 1'b1;
        cpu_addr = 16'h0000;
        cpu_we   = 1'b0;
        cpu_data = 8'h00;
        step(3);
        check("rst_active", {31'd0, dma_active}, 32'd0);
        check("rst_we", {31'd0, dma_we}, 32'd0);
        check("rst_addr", {16'd0, dma_addr}, 32'h0000);
        check("rst_data", {24'd0, dma_data}, 32'h00);
        check("rst_reg", {24'd0, dma_reg}, 32'h00);
        rst = 1'b0;
        step(2);

        // Basic transfer from page c1, with duration measurement.
        push_xfer(8'hc1, 0, 159);
        cpu_write(16'hff46, 8'hc1);
        check("t1_reg", {24'd0, dma_reg}, 32'hc1);
        check("t1_start_active", {31'd0, dma_active}, 32'd1);
        cnt = 0;
        while (dma_active && cnt < 2000) begin
            if (cnt == 1) check("t1_first_read", {16'd0, dma_addr}, 32'hc100);
            cnt++;
            step(1);
        end
        check("t1_active_cycles", cnt, 32'd321);
        check("t1_idle_addr", {16'd0, dma_addr}, 32'h0000);
        step(2);

        // Echo page e2 folds onto c2.
        push_xfer(8'hc2, 0, 159);
        cpu_write(16'hff46, 8'he2);
        check("t2_reg", {24'd0, dma_reg}, 32'he2);
        step(1);
        check("t2_first_read", {16'd0, dma_addr}, 32'hc200);
        wait_idle("t2");
        step(2);

        // Restart during WRITE at index 50.
        push_xfer(8'hc0, 0, 50);
        push_xfer(8'hd0, 0, 159);
        cpu_write(16'hff46, 8'hc0);
        step(102);
        check("t3_pre_restart_addr", {16'd0, dma_addr}, 32'hfe32);
        cpu_write(16'hff46, 8'hd0);
        check("t3_restart_active", {31'd0, dma_active}, 32'd1);
        check("t3_restart_we", {31'd0, dma_we}, 32'd0);
        step(1);
        check("t3_restart_read", {16'd0, dma_addr}, 32'hd000);
        wait_idle("t3");
        step(2);

        // Trigger coincides with the final WRITE.
        push_xfer(8'hc3, 0, 159);
        push_xfer(8'hc4, 0, 159);
        cpu_write(16'hff46, 8'hc3);
        step(320);
        check("t4_final_write_addr", {16'd0, dma_addr}, 32'hfe9f);
        cpu_write(16'hff46, 8'hc4);
        check("t4_start_not_idle", {31'd0, dma_active}, 32'd1);
        step(1);
        check("t4_read", {16'd0, dma_addr}, 32'hc400);
        wait_idle("t4");
        step(2);

        // Reset during WRITE at index 10 aborts the transfer.
        push_xfer(8'hc5, 0, 9);
        cpu_write(16'hff46, 8'hc5);
        step(22);
        check("t5_pre_reset_addr", {16'd0, dma_addr}, 32'hfe0a);
        rst = 1'b1;
        #1;
        check("t5_rst_active", {31'd0, dma_active}, 32'd0);
        check("t5_rst_we", {31'd0, dma_we}, 32'd0);
        check("t5_rst_addr", {16'd0, dma_addr}, 32'h0000);
        check("t5_rst_data", {24'd0, dma_data}, 32'h00);
        check("t5_rst_reg", {24'd0, dma_reg}, 32'h00);
        step(2);
        rst = 1'b0;
        step(400);
        check("t5_no_resume", {31'd0, dma_active}, 32'd0);

        // Neighbouring addresses are ignored.
        cpu_write(16'hff45, 8'hc1);
        check("t6_ff45_active", {31'd0, dma_active}, 32'd0);
        cpu_write(16'hff47, 8'hc1);
        check("t6_ff47_active", {31'd0, dma_active}, 32'd0);
        check("t6_reg", {24'd0, dma_reg}, 32'h00);
        step(5);
        check("t6_still_idle", {31'd0, dma_active}, 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dma_oam_ctrl.md
DMA_OAM_CTRL -- requirements
Module: dma_oam_ctrl

Interface
REQ-001 SHALL have parameter DMA_LENGTH, default 160, number of bytes copied per transfer.
REQ-002 SHALL have parameter OAM_BASE, default 16'hfe00, destination base address.
REQ-003 SHALL have parameter DMA_REG_ADDR, default 16'hff46, CPU address of the DMA trigger register.
REQ-004 SHALL have port iClock, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port iReset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port iCpuAddr, input, 16, CPU bus address.
REQ-007 SHALL have port iCpuWe, input, 1, CPU write strobe.
REQ-008 SHALL have port iCpuData, input, 8, CPU write data.
REQ-009 SHALL have port iMemReadData, input, 8, memory-system read data; valid one cycle after oDmaAddr is presented.
REQ-010 SHALL have port oDmaAddr, output, 16, DMA bus address (source in READ, destination in WRITE).
REQ-011 SHALL have port oDmaWe, output, 1, DMA write strobe to OAM.
REQ-012 SHALL have port oDmaData, output, 8, DMA write data.
REQ-013 SHALL have port oDmaActive, output, 1, high while the transfer owns the bus; the memory map selects the DMA bus over the CPU bus when high.
REQ-014 SHALL have port oDmaReg, output, 8, readback value of the DMA register.

Function
REQ-015 SHALL detect a trigger when iCpuWe=1 and iCpuAddr==DMA_REG_ADDR at a rising edge, latching iCpuData into oDmaReg and the source high byte.
REQ-016 SHALL map source high byte H to H & 8'hdf when H >= 8'he0 (echo region onto work RAM).
REQ-017 SHALL implement FSM states IDLE, START, READ, WRITE.
REQ-018 IDLE: oDmaActive=0, oDmaWe=0; on trigger -> START.
REQ-019 START: one cycle, oDmaActive=1, index cleared to 0; -> READ.
REQ-020 READ: oDmaAddr={src_hi, index}, oDmaWe=0; -> WRITE.
REQ-021 WRITE: oDmaAddr=OAM_BASE+index, oDmaData=iMemReadData, oDmaWe=1; if index==DMA_LENGTH-1 -> IDLE, else index+1 -> READ.
REQ-022 Index SHALL be 8 bits; no wrap beyond DMA_LENGTH-1 occurs.
REQ-023 Total latency from trigger edge to oDmaActive falling SHALL be 1+2*DMA_LENGTH cycles (321 at default).
REQ-024 A trigger in START, READ or WRITE SHALL restart: new source latched, -> START, index 0; the write of the current WRITE cycle is still performed.
REQ-025 A trigger coinciding with the final WRITE SHALL take priority over the return to IDLE.
REQ-026 CPU writes to addresses other than DMA_REG_ADDR SHALL be ignored by this block in all states.
REQ-027 oDmaAddr, oDmaData SHALL be 0 in IDLE.
REQ-028 Outputs SHALL be registered state-decoded; no combinational path from iCpu* to oDmaWe.

Reset
REQ-029 While iReset=1: state IDLE, index 0, source 0, oDmaReg=8'h00, oDmaActive=0, oDmaWe=0, oDmaAddr=16'h0000, oDmaData=8'h00.
REQ-030 Reset asserted mid-transfer SHALL abort immediately with no further oDmaWe pulses; the transfer is not resumed on deassertion.

Verification
REQ-031 Write 8'hc1 to ff46 -> oDmaReg=c1; START next cycle; first READ addr c100, first WRITE addr fe00 with data from c100; last WRITE fe9f with data from c19f; oDmaActive high for exactly 321 cycles.
REQ-032 Write 8'he2 to ff46 -> source addresses c200..c29f.
REQ-033 Write 8'hc0 then, at index 50, write 8'hd0 -> write to fe32 completes, restart at START, next READ d000, final WRITE fe9f from d09f.
REQ-034 Trigger on cycle of final WRITE (fe9f) -> fe9f written, FSM enters START, not IDLE.
REQ-035 Assert iReset during WRITE at index 10 -> all outputs zero same cycle, no oDmaWe after release, oDmaReg=00.
REQ-036 CPU writes to ff45 and ff47 in IDLE -> no state change, oDmaActive stays 0.
